// File: rtl/systolic_feeder.sv
// Skewed operand feeder for an N x N output-stationary systolic array.
// Captures an A/B matrix pair, clears the array, streams diagonally skewed rows/columns, then drains.
module systolic_feeder #(
  parameter int N     = 4,
  parameter int DW    = 16,
  parameter int DRAIN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*N*DW-1:0] mat_a,
  input  logic [N*N*DW-1:0] mat_b,
  output logic [N*DW-1:0]   a,
  output logic [N*DW-1:0]   b,
  output logic              clr,
  output logic              feed_valid,
  output logic              done
);

  localparam int SW  = $clog2(2 * N);
  localparam int DCW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [SW-1:0]  LAST_STEP  = SW'(2 * N - 2);
  localparam logic [DCW-1:0] LAST_DRAIN = DCW'((DRAIN > 0) ? DRAIN - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN} state_t;

  state_t              state;
  logic [SW-1:0]       step;
  logic [DCW-1:0]      dcnt;
  logic [N*N*DW-1:0]   cap_a, cap_b;
  logic [SW-1:0]       sel;
  logic [N*DW-1:0]     a_skew, b_skew;

  assign in_ready = (state == S_IDLE);

  // Outputs are registered, so the skew is computed for the step about to be presented.
  always_comb begin
    int t;
    int k;
    sel    = (state == S_FEED) ? step + 1'b1 : '0;
    a_skew = '0;
    b_skew = '0;
    t      = int'(sel);
    for (int unsigned i = 0; i < N; i++) begin
      k = t - int'(i);
      if (k >= 0 && k < N) begin
        a_skew[i*DW +: DW] = cap_a[(N * int'(i) + k) * DW +: DW];
        b_skew[i*DW +: DW] = cap_b[(N * k + int'(i)) * DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      step       <= '0;
      dcnt       <= '0;
      cap_a      <= '0;
      cap_b      <= '0;
      a          <= '0;
      b          <= '0;
      clr        <= 1'b0;
      feed_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      clr  <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            cap_a <= mat_a;
            cap_b <= mat_b;
            clr   <= 1'b1;
            state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          step       <= '0;
          a          <= a_skew;
          b          <= b_skew;
          feed_valid <= 1'b1;
          state      <= S_FEED;
        end
        S_FEED: begin
          if (step == LAST_STEP) begin
            a          <= '0;
            b          <= '0;
            feed_valid <= 1'b0;
            dcnt       <= '0;
            if (DRAIN == 0) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              state <= S_DRAIN;
            end
          end else begin
            step <= step + 1'b1;
            a    <= a_skew;
            b    <= b_skew;
          end
        end
        S_DRAIN: begin
          if (dcnt == LAST_DRAIN) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder with a behavioural output-stationary array model on its outputs.
module tb_systolic_feeder;
  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int DRAIN = 4;
  localparam int W     = N * DW;
  localparam int MW    = N * N * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [MW-1:0] mat_a = '0;
  logic [MW-1:0] mat_b = '0;
  logic          in_ready, clr, feed_valid, done;
  logic [W-1:0]  a, b;

  systolic_feeder #(.N(N), .DW(DW), .DRAIN(DRAIN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mat_a(mat_a), .mat_b(mat_b), .a(a), .b(b),
    .clr(clr), .feed_valid(feed_valid), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b;
    logic         clr, fv, done, rdy;
  } exp_t;

  exp_t q[$];
  int   done_cyc[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output-stationary array: a flows right, b flows down, each PE accumulates a*b.
  logic [39:0]   acc [N][N];
  logic [DW-1:0] ar  [N][N];
  logic [DW-1:0] br  [N][N];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j] <= '0; ar[i][j] <= '0; br[i][j] <= '0;
        end
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          logic [DW-1:0] ain, bin;
          ain = (j == 0) ? a[i*DW +: DW] : ar[i][j-1];
          bin = (i == 0) ? b[j*DW +: DW] : br[i-1][j];
          acc[i][j] <= clr ? 40'd0 : acc[i][j] + 40'(ain) * 40'(bin);
          ar[i][j]  <= ain;
          br[i][j]  <= bin;
        end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] elem(input logic [MW-1:0] m, input int r, input int c);
    return m[(N * r + c) * DW +: DW];
  endfunction

  task automatic push_seq(input logic [MW-1:0] ma, input logic [MW-1:0] mb);
    exp_t e;
    e.a = '0; e.b = '0; e.clr = 1'b1; e.fv = 1'b0; e.done = 1'b0; e.rdy = 1'b0;
    q.push_back(e);
    e.clr = 1'b0; e.fv = 1'b1;
    for (int t = 0; t < 2 * N - 1; t++) begin
      e.a = '0; e.b = '0;
      for (int i = 0; i < N; i++) begin
        if (t - i >= 0 && t - i < N) begin
          e.a[i*DW +: DW] = elem(ma, i, t - i);
          e.b[i*DW +: DW] = elem(mb, t - i, i);
        end
      end
      q.push_back(e);
    end
    e.a = '0; e.b = '0; e.fv = 1'b0;
    repeat (DRAIN) q.push_back(e);
    e.done = 1'b1; e.rdy = 1'b1;
    q.push_back(e);
  endtask

  task automatic push_idle();
    exp_t e;
    e.a = '0; e.b = '0; e.clr = 1'b0; e.fv = 1'b0; e.done = 1'b0; e.rdy = 1'b1;
    q.push_back(e);
  endtask

  task automatic step_cycle();
    exp_t e;
    @(negedge clk);
    if (done) done_cyc.push_back(cyc);
    check("sb_nonempty", 64'(q.size() > 0), 64'd1);
    if (q.size() > 0) begin
      e = q.pop_front();
      check("a", 64'(a), 64'(e.a));
      check("b", 64'(b), 64'(e.b));
      check("clr", 64'(clr), 64'(e.clr));
      check("feed_valid", 64'(feed_valid), 64'(e.fv));
      check("done", 64'(done), 64'(e.done));
      check("in_ready", 64'(in_ready), 64'(e.rdy));
    end
  endtask

  task automatic check_result(input string tag, input logic [MW-1:0] m);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        check(tag, 64'(acc[r][c]), 64'(elem(m, r, c)));
  endtask

  logic [MW-1:0] ma1, mid, ma2, mb2;

  initial begin
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma1[(N*r+c)*DW +: DW] = DW'(4 * r + c + 1);
        mid[(N*r+c)*DW +: DW] = (r == c) ? DW'(1) : DW'(0);
        ma2[(N*r+c)*DW +: DW] = DW'(16 * r + c + 100);
        mb2[(N*r+c)*DW +: DW] = DW'(3 * c + r + 7);
      end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_a", 64'(a), 64'd0);
    check("rst_b", 64'(b), 64'd0);
    check("rst_clr", 64'(clr), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_fv", 64'(feed_valid), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    // Skew pattern with B = identity
    mat_a = ma1; mat_b = mid; in_valid = 1'b1;
    push_seq(ma1, mid);
    step_cycle(); in_valid = 1'b0;
    step_cycle();
    check("step0_a", 64'(a), 64'h0000_0000_0000_0001);
    check("step0_b", 64'(b), 64'h0000_0000_0000_0001);
    repeat (3) step_cycle();
    check("step3_a", 64'(a), 64'h000D_000A_0007_0004);
    check("step3_b", 64'(b), 64'h0);
    repeat (3) step_cycle();
    check("step6_a", 64'(a), 64'h0010_0000_0000_0000);
    check("step6_b", 64'(b), 64'h0001_0000_0000_0000);
    repeat (5) step_cycle();
    check_result("array_axi", ma1);
    push_idle(); step_cycle();

    // Busy ignore: new request and changed mat_a during FEED
    mat_a = ma1; mat_b = mid; in_valid = 1'b1;
    push_seq(ma1, mid);
    step_cycle(); in_valid = 1'b0;
    repeat (3) step_cycle();
    in_valid = 1'b1; mat_a = '1;
    check("busy_ready", 64'(in_ready), 64'd0);
    repeat (5) step_cycle();
    in_valid = 1'b0;
    repeat (4) step_cycle();
    push_idle(); step_cycle();

    // Back-to-back pairs with in_valid held high
    done_cyc.delete();
    mat_a = ma1; mat_b = mid; in_valid = 1'b1;
    push_seq(ma1, mid);
    push_seq(ma2, mb2);
    step_cycle(); mat_a = ma2; mat_b = mb2;
    repeat (13) step_cycle();
    in_valid = 1'b0;
    repeat (12) step_cycle();
    push_idle(); step_cycle();
    check("b2b_done_count", 64'(done_cyc.size()), 64'd2);
    if (done_cyc.size() == 2) check("b2b_done_gap", 64'(done_cyc[1] - done_cyc[0]), 64'd13);

    // Identity run after a prior nonzero result: clr must wipe the accumulators
    mat_a = mid; mat_b = mid; in_valid = 1'b1;
    push_seq(mid, mid);
    step_cycle(); in_valid = 1'b0;
    repeat (12) step_cycle();
    check_result("array_ixi", mid);
    push_idle(); step_cycle();

    // Reset in the middle of FEED
    done_cyc.delete();
    mat_a = ma1; mat_b = mid; in_valid = 1'b1;
    push_seq(ma1, mid);
    step_cycle(); in_valid = 1'b0;
    repeat (4) step_cycle();
    #2 rst_n = 1'b0;
    #1;
    check("mrst_a", 64'(a), 64'd0);
    check("mrst_b", 64'(b), 64'd0);
    check("mrst_clr", 64'(clr), 64'd0);
    check("mrst_fv", 64'(feed_valid), 64'd0);
    check("mrst_done", 64'(done), 64'd0);
    check("mrst_ready", 64'(in_ready), 64'd1);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) push_idle();
    repeat (3) step_cycle();
    check("mrst_no_done", 64'(done_cyc.size()), 64'd0);

    // Fresh sequence after reset release
    mat_a = ma1; mat_b = mid; in_valid = 1'b1;
    push_seq(ma1, mid);
    step_cycle(); in_valid = 1'b0;
    repeat (12) step_cycle();
    check_result("array_fresh", ma1);
    push_idle(); step_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
